// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg
// Shared definitions for the uio pad-bank arbiter: FSM state encoding,
// pad width and the two output-enable patterns used on the uio bank.
// Optional build macro used by the arbiter files: UIO_ARB_FIXED_PRIO_EN
// (fixed lowest-index-wins priority instead of round-robin).

package uio_arb_pkg;

    // Arbiter phases: waiting for a request, one dead turnaround cycle,
    // then the byte-beat transfer itself.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam int UIO_W = 8;

    localparam logic [UIO_W-1:0] OE_DRIVE = 8'hFF;
    localparam logic [UIO_W-1:0] OE_HIZ   = 8'h00;

endpackage

// File: rtl/uio_rr_pick.sv
// uio_rr_pick
// Combinational winner selection for the uio arbiter.
// Default build: rotating priority encoder whose search starts at
// prev_owner + 1 and wraps at N_REQ, so the last owner has lowest priority.
// With UIO_ARB_FIXED_PRIO_EN defined it degenerates to a fixed-priority
// encoder (lowest index wins) and the prev_owner port disappears.
//
// Ports:
//   req        in  N_REQ  - pending requests
//   prev_owner in  IDX_W  - index of the last granted requester (RR build only)
//   winner     out IDX_W  - index of the selected requester (0 when none)
//   any        out 1      - at least one request is pending

module uio_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifndef UIO_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] prev_owner,
`endif
    output logic [IDX_W-1:0] winner,
    output logic             any
);

`ifdef UIO_ARB_FIXED_PRIO_EN

    // Scan from the highest index down so the lowest set index is the
    // final assignment and therefore wins.
    always_comb begin
        winner = '0;
        any    = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) begin
                winner = IDX_W'(i);
            end
        end
    end

`else

    int idx;

    // Walk the ring backwards from prev_owner + N_REQ (the previous owner
    // itself) to prev_owner + 1. The last hit is the one closest after the
    // previous owner, which is the round-robin winner.
    always_comb begin
        winner = '0;
        any    = |req;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(prev_owner) + k) % N_REQ;
            if (req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
            end
        end
    end

`endif

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
// Shares the 8-bit bidirectional uio pad bank between N_REQ requesters.
// One owner at a time, grants capped at MAX_BURST beats, and a turnaround
// cycle with the pads released between owners.
// Build macro: UIO_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round-robin arbitration.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - tile enable; low blocks new grants and beats
//   req[N_REQ]   - level-sensitive requests
//   dir[N_REQ]   - per-requester direction, 1 = write pads, 0 = read pads
//   wdata        - write bytes, requester i on bits [8i+7:8i]
//   gnt[N_REQ]   - one-hot owner, valid in TURN and XFER
//   beat         - a byte moves for the owner this cycle
//   last         - this beat is the final beat allowed in the grant
//   rdata        - byte captured on the most recent read beat
//   rdata_valid  - pulses the cycle after a read beat
//   uio_in       - pad input
//   uio_out      - pad output (registered)
//   uio_oe       - pad output enable (registered), 1 = drive

module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       dir,
    input  logic [UIO_W*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic                   beat,
    output logic                   last,
    output logic [UIO_W-1:0]       rdata,
    output logic                   rdata_valid,
    input  logic [UIO_W-1:0]       uio_in,
    output logic [UIO_W-1:0]       uio_out,
    output logic [UIO_W-1:0]       uio_oe
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic             dir_q;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic [UIO_W-1:0] wdata_arr [N_REQ];
    logic [UIO_W-1:0] owner_wdata;
    logic             write_beat;
    logic             read_beat;

    // Split the flat write bus into one byte per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_wdata
        assign wdata_arr[g] = wdata[g*UIO_W +: UIO_W];
    end

`ifdef UIO_ARB_FIXED_PRIO_EN

    uio_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .winner (pick_idx),
        .any    (pick_any)
    );

`else

    logic [IDX_W-1:0] prev_owner;

    uio_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .prev_owner (prev_owner),
        .winner     (pick_idx),
        .any        (pick_any)
    );

    // prev_owner starts at the top index so requester 0 wins the first
    // search after reset; it follows every issued grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_owner <= IDX_W'(N_REQ - 1);
        end else if (state == IDLE && ena && pick_any) begin
            prev_owner <= pick_idx;
        end
    end

`endif

    // A beat needs the owner still requesting in the direction latched at
    // grant time; any other case (req drop, dir change, ena low) ends the
    // grant without moving a byte.
    always_comb begin
        gnt         = '0;
        owner_wdata = wdata_arr[owner];
        beat        = 1'b0;
        last        = 1'b0;
        if (state != IDLE) begin
            gnt[owner] = 1'b1;
        end
        if (state == XFER) begin
            beat = ena & req[owner] & (dir[owner] == dir_q);
            last = beat & (cnt == CNT_W'(MAX_BURST - 1));
        end
        write_beat = beat & dir_q;
        read_beat  = beat & ~dir_q;
    end

    // Grant FSM: owner and direction are frozen at grant time, the beat
    // counter enforces the burst cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            dir_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && pick_any) begin
                        owner <= pick_idx;
                        dir_q <= dir[pick_idx];
                        cnt   <= '0;
                        state <= TURN;
                    end
                end
                TURN: begin
                    state <= XFER;
                end
                XFER: begin
                    if (!beat) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pad and read-data registers. The output enable follows write beats,
    // so the byte of a write beat appears with the pads driven one cycle
    // later, and the pads release on the cycle after the final write beat
    // even when the grant ends by a dropped request or a low ena. TURN is
    // never preceded by a write beat, so it always sees the pads released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uio_out     <= '0;
            uio_oe      <= OE_HIZ;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            uio_oe      <= write_beat ? OE_DRIVE : OE_HIZ;
            rdata_valid <= read_beat;
            if (write_beat) begin
                uio_out <= owner_wdata;
            end
            if (read_beat) begin
                rdata <= uio_in;
            end
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter
// Directed bench for uio_bus_arbiter (N_REQ = 4, MAX_BURST = 8, default
// round-robin build). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge, so each applyStimulus call is one cycle.

module tb_uio_bus_arbiter;

    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 8;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        beat;
    logic        last;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int testCount = 0;
    int failCount = 0;

    uio_bus_arbiter #(
        .N_REQ     (N_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .req         (req),
        .dir         (dir),
        .wdata       (wdata),
        .gnt         (gnt),
        .beat        (beat),
        .last        (last),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .uio_in      (uio_in),
        .uio_out     (uio_out),
        .uio_oe      (uio_oe)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs after the rising edge, then wait for the
    // falling edge where that cycle's outputs are sampled.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic e);
        @(posedge clk);
        #1;
        req = r;
        dir = d;
        ena = e;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    logic [3:0] rrGnt [3];

    initial begin
        rrGnt = '{4'b0100, 4'b0001, 4'b0100};
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = 4'hF;
        dir    = 4'h0;
        wdata  = {8'h44, 8'h33, 8'h22, 8'hA5};
        uio_in = 8'h3C;

        // Reset with every request high: all outputs quiet.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_beat", beat, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rvalid", rdata_valid, 0);
        checkOutput("rst_out", uio_out, 0);
        checkOutput("rst_oe", uio_oe, 0);

        // Release: requester 0 wins the first search.
        rst_n = 1'b1;
        applyStimulus(4'hF, 4'h0, 1'b1);
        checkOutput("first_gnt", gnt, 4'b0001);
        checkOutput("first_turn_beat", beat, 0);
        applyStimulus(4'h0, 4'h0, 1'b1);
        checkOutput("first_drop_beat", beat, 0);
        checkOutput("first_drop_gnt", gnt, 4'b0001);
        applyStimulus(4'h0, 4'h0, 1'b1);
        checkOutput("first_idle_gnt", gnt, 0);

        // Write burst by requester 0, three beats then request dropped.
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        checkOutput("wr_c0_gnt", gnt, 0);
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        checkOutput("wr_c1_gnt", gnt, 4'b0001);
        checkOutput("wr_c1_beat", beat, 0);
        checkOutput("wr_c1_oe", uio_oe, 8'h00);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(4'b0001, 4'b0001, 1'b1);
            checkOutput("wr_beat", beat, 1);
            checkOutput("wr_last", last, 0);
            if (k >= 3) begin
                checkOutput("wr_out", uio_out, 8'hA5);
                checkOutput("wr_oe", uio_oe, 8'hFF);
            end else begin
                checkOutput("wr_c2_oe", uio_oe, 8'h00);
            end
        end
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        checkOutput("wr_c5_beat", beat, 0);
        checkOutput("wr_c5_oe", uio_oe, 8'hFF);
        checkOutput("wr_c5_out", uio_out, 8'hA5);
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        checkOutput("wr_c6_oe", uio_oe, 8'h00);
        checkOutput("wr_c6_gnt", gnt, 0);

        // Burst cap: requester 1 writes continuously, cut at 8 beats.
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("cap_turn_gnt", gnt, 4'b0010);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(4'b0010, 4'b0010, 1'b1);
            checkOutput("cap_beat", beat, 1);
            checkOutput("cap_last", last, (k == 8) ? 1 : 0);
        end
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("cap_idle_gnt", gnt, 0);
        checkOutput("cap_idle_beat", beat, 0);
        checkOutput("cap_idle_oe", uio_oe, 8'hFF);
        checkOutput("cap_idle_out", uio_out, 8'h22);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("cap_regrant", gnt, 4'b0010);
        checkOutput("cap_regrant_oe", uio_oe, 8'h00);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("cap_b9_beat", beat, 1);
        checkOutput("cap_b9_last", last, 0);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        applyStimulus(4'b0000, 4'b0010, 1'b1);
        applyStimulus(4'b0000, 4'b0010, 1'b1);

        // Round-robin reads by requesters 0 and 2; last owner was 1, so 2 leads.
        uio_in = 8'hC3;
        applyStimulus(4'b0101, 4'b0000, 1'b1);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(4'b0101, 4'b0000, 1'b1);
            checkOutput("rr_gnt", gnt, rrGnt[g]);
            for (int k = 1; k <= 8; k++) begin
                applyStimulus(4'b0101, 4'b0000, 1'b1);
                checkOutput("rr_beat", beat, 1);
                checkOutput("rr_last", last, (k == 8) ? 1 : 0);
                checkOutput("rr_oe", uio_oe, 8'h00);
                if (k > 1) begin
                    checkOutput("rr_rdata", rdata, 8'hC3);
                    checkOutput("rr_rvalid", rdata_valid, 1);
                end
            end
            applyStimulus(4'b0101, 4'b0000, 1'b1);
            checkOutput("rr_idle_gnt", gnt, 0);
            checkOutput("rr_idle_rvalid", rdata_valid, 1);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("rr_fourth_gnt", gnt, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("rr_end_beat", beat, 0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);

        // Turnaround: full write burst by 0, then a read by 3.
        uio_in = 8'h3C;
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        checkOutput("ta_wr_gnt", gnt, 4'b0001);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(4'b0001, 4'b0001, 1'b1);
            checkOutput("ta_wr_beat", beat, 1);
        end
        applyStimulus(4'b1000, 4'b0001, 1'b1);
        checkOutput("ta_idle_gnt", gnt, 0);
        checkOutput("ta_idle_oe", uio_oe, 8'hFF);
        checkOutput("ta_idle_out", uio_out, 8'hA5);
        applyStimulus(4'b1000, 4'b0001, 1'b1);
        checkOutput("ta_turn_gnt", gnt, 4'b1000);
        checkOutput("ta_turn_oe", uio_oe, 8'h00);
        applyStimulus(4'b1000, 4'b0001, 1'b1);
        checkOutput("ta_rd1_beat", beat, 1);
        checkOutput("ta_rd1_oe", uio_oe, 8'h00);
        applyStimulus(4'b1000, 4'b0001, 1'b1);
        checkOutput("ta_rd2_rdata", rdata, 8'h3C);
        checkOutput("ta_rd2_rvalid", rdata_valid, 1);
        checkOutput("ta_rd2_oe", uio_oe, 8'h00);
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        checkOutput("ta_drop_beat", beat, 0);
        checkOutput("ta_drop_rvalid", rdata_valid, 1);
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        checkOutput("ta_end_rvalid", rdata_valid, 0);
        checkOutput("ta_end_rdata", rdata, 8'h3C);

        // ena dropped mid-transfer by requester 2 (writer).
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        checkOutput("ena_turn_gnt", gnt, 4'b0100);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        checkOutput("ena_wr_oe", uio_oe, 8'hFF);
        checkOutput("ena_wr_out", uio_out, 8'h33);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        checkOutput("ena_low_beat", beat, 0);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        checkOutput("ena_next_gnt", gnt, 0);
        checkOutput("ena_next_beat", beat, 0);
        checkOutput("ena_next_oe", uio_oe, 8'h00);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        checkOutput("ena_hold_gnt", gnt, 0);

        // Reset pulsed mid-transfer: outputs clear without waiting for a clock.
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        checkOutput("rstab_turn_gnt", gnt, 4'b0100);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 1'b1);
        checkOutput("rstab_pre_oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
        #1;
        checkOutput("rstab_gnt", gnt, 0);
        checkOutput("rstab_beat", beat, 0);
        checkOutput("rstab_oe", uio_oe, 8'h00);
        checkOutput("rstab_out", uio_out, 8'h00);
        applyStimulus(4'hF, 4'h0, 1'b1);
        checkOutput("rstab_hold_beat", beat, 0);
        checkOutput("rstab_hold_gnt", gnt, 0);
        rst_n = 1'b1;
        applyStimulus(4'hF, 4'h0, 1'b1);
        checkOutput("rstab_first_gnt", gnt, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
